inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Parametrised instruction-fetch front end for the MiniMIPS32 core, sitting between the IF stage and an SRAM-like instruction bus. It replaces the single-cycle iaddr/ice/inst path with a variable-latency request/response interface and a DEPTH-entry in-order queue of {pc, inst} pairs. The ID stage consumes the queue through a valid/ready handshake. Branch, jump and exception redirects flush the queue and discard in-flight responses.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2; also bounds total outstanding requests
- ADDR_W, 32: PC / bus address width
- DATA_W, 32: instruction width
- RESET_PC, 32'hBFC0_0000: fetch PC after reset
- cpu_clk_50M  in  1  clock; all state on rising edge
- cpu_rst  in  1  reset; synchronous, active-high
- redirect  in  1  flush queue and restart fetch at redirect_pc (branch, jump, cp0_excaddr)
- redirect_pc  in  ADDR_W  new fetch PC
- inst_req  out  1  bus request valid
- inst_addr  out  ADDR_W  request address; equals fetch_pc
- inst_addr_ok  in  1  request accepted this cycle (valid only while inst_req=1)
- inst_data_ok  in  1  response valid; responses return in request order
- inst_rdata  in  DATA_W  response data
- out_valid  out  1  head entry ready for ID
- out_pc  out  ADDR_W  head PC
- out_inst  out  DATA_W  head instruction; 0 when out_adel=1
- out_adel  out  1  head is a misaligned-fetch exception entry
- out_ready  in  1  ID accepts head (ID not stalled)
- occupancy  out  $clog2(DEPTH)+1  allocated entries

## Operation
- Counters: alloc_cnt (entries allocated, filled or not), live_inflight (accepted, not returned, not discarded), discard_cnt (accepted before a redirect, still outstanding).
- Issue condition: !redirect && !halted && fetch_pc[1:0]==0 && alloc_cnt < DEPTH && live_inflight+discard_cnt < DEPTH.
- inst_req is high whenever the issue condition holds. Once high, inst_addr stays stable until inst_addr_ok. The only exception is redirect, which may withdraw an un-accepted request.
- On inst_req && inst_addr_ok:
  - allocate the tail entry {pc=fetch_pc, filled=0}
  - fetch_pc += 4
  - live_inflight++
- On inst_data_ok:
  - if discard_cnt>0: discard_cnt--, data dropped
  - else: fill the oldest unfilled entry, live_inflight--
- Misaligned fetch (fetch_pc[1:0]≠0, room available):
  - no bus request
  - allocate an entry pre-filled with inst=0, adel=1
  - set halted; fetch stops until redirect
- Pop: out_valid && out_ready frees the head.
- Redirect (highest priority):
  - entries cleared, alloc_cnt=0
  - discard_cnt += live_inflight, plus 1 if addr_ok is accepted in the same cycle
  - live_inflight=0, halted=0
  - fetch_pc=redirect_pc
  - a same-cycle pop, fill or alloc is ignored
  - a data_ok in the same cycle still decrements discard_cnt if it was >0 beforehand
- Arithmetic: fetch_pc wraps modulo 2^ADDR_W. Pointers wrap modulo DEPTH.

## Timing
- Reset values: inst_req=0, inst_addr=RESET_PC, out_valid=0, out_pc=0, out_inst=0, out_adel=0, occupancy=0, all counters 0, halted=0.
- cpu_rst high in any cycle, including mid-transaction, forces these values next cycle. The bus is expected to be reset in the same cycle.
- First inst_req=1: the first cycle after cpu_rst deasserts.
- Latency: addr_ok in cycle t, data_ok in cycle t+k (k≥1), out_valid=1 at t+k+1.
- Outputs are driven from registered head state.
- Back-to-back: with addr_ok and data_ok asserted every cycle, the block sustains one instruction per cycle.
- Full: alloc_cnt==DEPTH drops inst_req. A pop in cycle t re-enables inst_req at t+1, not in the same cycle.
- Simultaneous pop+alloc+fill in one cycle is legal; occupancy changes by alloc−pop.
- Redirect in cycle t:
  - out_valid=0 at t+1
  - inst_req=1 with inst_addr=redirect_pc at t+1, provided discard headroom allows

## Structure
- Shared package entries (MiniMIPS32 defines): RESET_PC value, INST_W, and the ADEL exception code used by downstream exccode.
- Sub-module ifq_entry_buf: DEPTH×{pc, inst, filled, adel} storage with head, tail and fill pointers, plus alloc/fill/pop/clear ports.
- inst_fetch_queue holds fetch_pc, the counters, halted, and the bus handshake.

## Test plan
- Reset then zero-wait bus (addr_ok=1 always, data_ok one cycle later), out_ready=1:
  - out_pc sequence BFC00000, BFC00004, … with one per cycle
  - out_inst matches memory
- out_ready=0 with DEPTH=4:
  - exactly 4 requests accepted, then inst_req=0
  - occupancy=4
  - releasing out_ready for one cycle gives exactly one new request the following cycle
- Bus latency k=3 with random addr_ok stalls:
  - inst_addr held stable while inst_req=1 && !addr_ok
  - instruction order preserved
- Redirect to 80001000 with 2 requests in flight:
  - the next 2 data_ok beats are dropped
  - first out_pc=80001000 with its correct inst
  - out_valid=0 in the cycle after redirect
- Redirect to 80001002:
  - no inst_req issued
  - one entry with out_adel=1, out_inst=0, out_pc=80001002
  - fetch halted until a redirect to 80002000 resumes it
- cpu_rst asserted mid-burst:
  - next cycle all outputs at reset values
  - fetch restarts at BFC00000

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared MiniMIPS32 fetch-front-end definitions: reset vector, instruction width,
// the address-error exception code and the per-cycle fetch action encoding.
package inst_fetch_queue_pkg;
  localparam int          INST_W        = 32;
  localparam logic [31:0] MIPS_RESET_PC = 32'hBFC0_0000;
  localparam logic [4:0]  EXC_ADEL      = 5'h04;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_ISSUE = 2'd1,
    FETCH_ADEL  = 2'd2
  } fetch_act_e;

  function automatic logic pc_aligned(input logic [1:0] pc_lo);
    return pc_lo == 2'b00;
  endfunction
endpackage

// File: rtl/inst_fetch_queue_entry_buf.sv
// In-order {pc, inst, filled, adel} entry store with separate head, tail and fill
// pointers so entries are allocated at issue time and filled as responses return.
module ifq_entry_buf
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = INST_W
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              clear,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              alloc_adel,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_inst,
  input  logic              pop,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_inst,
  output logic              head_adel
);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [DEPTH-1:0]  filled_q, filled_d, adel_q, adel_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d, fill_ptr_q, fill_ptr_d;

  // Alloc (tail) never aliases pop (head, filled) or fill (allocated, unfilled).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic pop_hit, alloc_hit, fill_hit;
    assign pop_hit      = pop   && (head_q     == PW'(gi));
    assign alloc_hit    = alloc && (tail_q     == PW'(gi));
    assign fill_hit     = fill  && (fill_ptr_q == PW'(gi));
    assign filled_d[gi] = clear ? 1'b0 :
                          alloc_hit ? alloc_adel : (fill_hit || (filled_q[gi] && !pop_hit));
    assign adel_d[gi]   = clear ? 1'b0 :
                          alloc_hit ? alloc_adel : (adel_q[gi] && !pop_hit);
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    fill_ptr_d = fill_ptr_q;
    if (clear) begin
      head_d     = '0;
      tail_d     = '0;
      fill_ptr_d = '0;
    end else begin
      if (pop)   head_d     = head_q + PW'(1);
      if (alloc) tail_d     = tail_q + PW'(1);
      if (fill)  fill_ptr_d = fill_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      filled_q   <= '0;
      adel_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_ptr_q <= '0;
    end else begin
      filled_q   <= filled_d;
      adel_q     <= adel_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_ptr_q <= fill_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc && !clear) pc_mem[tail_q]       <= alloc_pc;
    if (fill && !clear)  inst_mem[fill_ptr_q] <= fill_inst;
  end

  assign head_valid = filled_q[head_q];
  assign head_pc    = pc_mem[head_q];
  assign head_inst  = inst_mem[head_q];
  assign head_adel  = adel_q[head_q];
endmodule

// File: rtl/inst_fetch_queue.sv
// MiniMIPS32 instruction-fetch front end: variable-latency bus requests feeding an
// in-order queue, with redirect flush and discard of responses already in flight.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(MIPS_RESET_PC)
) (
  input  logic                   cpu_clk_50M,
  input  logic                   cpu_rst,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   inst_req,
  output logic [ADDR_W-1:0]      inst_addr,
  input  logic                   inst_addr_ok,
  input  logic                   inst_data_ok,
  input  logic [DATA_W-1:0]      inst_rdata,
  output logic                   out_valid,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [DATA_W-1:0]      out_inst,
  output logic                   out_adel,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     alloc_cnt_q, alloc_cnt_d, live_q, live_d, discard_q, discard_d;
  logic              halted_q, halted_d;
  logic [CW:0]       outstanding;
  fetch_act_e        act;
  logic              accept, drop, landed, do_fill, do_pop, do_alloc;
  logic              head_valid, head_adel;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_inst;

  assign outstanding = {1'b0, live_q} + {1'b0, discard_q};

  always_comb begin
    act = FETCH_IDLE;
    if (!cpu_rst && !redirect && !halted_q && (alloc_cnt_q < DEPTH_C)) begin
      if (!pc_aligned(fetch_pc_q[1:0]))       act = FETCH_ADEL;
      else if (outstanding < {1'b0, DEPTH_C}) act = FETCH_ISSUE;
    end
  end

  assign inst_req  = (act == FETCH_ISSUE);
  assign inst_addr = fetch_pc_q;
  assign accept    = inst_req && inst_addr_ok;
  assign drop      = inst_data_ok && (discard_q != '0);
  assign landed    = inst_data_ok && !drop && (live_q != '0);
  assign do_fill   = landed && !redirect;
  assign do_pop    = head_valid && out_ready && !redirect;
  assign do_alloc  = accept || (act == FETCH_ADEL);

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    alloc_cnt_d = alloc_cnt_q;
    live_d      = live_q;
    halted_d    = halted_q;
    discard_d   = drop ? discard_q - CW'(1) : discard_q;
    if (redirect) begin
      fetch_pc_d  = redirect_pc;
      alloc_cnt_d = '0;
      live_d      = '0;
      halted_d    = 1'b0;
      // A live response landing right now has already returned; only the rest become discards.
      discard_d   = discard_d + live_q - CW'(landed) + CW'(accept);
    end else begin
      if (accept)             fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (act == FETCH_ADEL)  halted_d   = 1'b1;
      alloc_cnt_d = alloc_cnt_q + CW'(do_alloc) - CW'(do_pop);
      live_d      = live_q + CW'(accept) - CW'(do_fill);
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      fetch_pc_q  <= RESET_PC;
      alloc_cnt_q <= '0;
      live_q      <= '0;
      discard_q   <= '0;
      halted_q    <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      alloc_cnt_q <= alloc_cnt_d;
      live_q      <= live_d;
      discard_q   <= discard_d;
      halted_q    <= halted_d;
    end
  end

  ifq_entry_buf #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk        (cpu_clk_50M),
    .srst       (cpu_rst),
    .clear      (redirect),
    .alloc      (do_alloc),
    .alloc_pc   (fetch_pc_q),
    .alloc_adel (act == FETCH_ADEL),
    .fill       (do_fill),
    .fill_inst  (inst_rdata),
    .pop        (do_pop),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_inst  (head_inst),
    .head_adel  (head_adel)
  );

  assign out_valid = head_valid;
  assign out_pc    = head_valid ? head_pc : '0;
  assign out_inst  = (head_valid && !head_adel) ? head_inst : '0;
  assign out_adel  = head_valid && head_adel;
  assign occupancy = alloc_cnt_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: cycle table for the zero-wait/full cases, then
// hand sequences for random stalls, redirects, misaligned fetch and mid-burst reset.
module tb_inst_fetch_queue;
  localparam logic [31:0] B = 32'hBFC0_0000;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst     = 1'b1;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata   = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adel;
  logic        out_ready = 1'b0;
  logic [2:0]  occupancy;

  inst_fetch_queue dut (
    .cpu_clk_50M  (cpu_clk_50M),
    .cpu_rst      (cpu_rst),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_adel     (out_adel),
    .out_ready    (out_ready),
    .occupancy    (occupancy)
  );

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  // Bus model: in-order responses k cycles after acceptance.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];
  int cyc = 0, bus_k = 1, bus_mode = 0, budget = 0;

  always @(posedge cpu_clk_50M) begin
    if (cpu_rst) pend.delete();
    else begin
      if (inst_data_ok && pend.size() > 0) void'(pend.pop_front());
      if (inst_req && inst_addr_ok) begin
        pend.push_back('{inst_addr, cyc + bus_k});
        if (budget > 0) budget--;
      end
    end
    cyc++;
    #2;
    case (bus_mode)
      0:       inst_addr_ok = 1'b1;
      1:       inst_addr_ok = 1'($urandom_range(0, 1));
      default: inst_addr_ok = (budget > 0);
    endcase
    inst_data_ok = (pend.size() > 0) && (pend[0].due <= cyc);
    inst_rdata   = inst_data_ok ? mem(pend[0].addr) : 32'hDEAD_BEEF;
  end

  // Pop scoreboard and request-hold monitor.
  bit          mon_en = 1'b0;
  logic [31:0] exp_pc = B;
  int          pops = 0;
  bit          prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge cpu_clk_50M) begin
    if (mon_en && out_valid && out_ready && !redirect && !cpu_rst) begin
      $display("pop pc=%08h inst=%08h", out_pc, out_inst);
      chk("pop_pc", out_pc, exp_pc);
      chk("pop_inst", out_inst, mem(exp_pc));
      chk("pop_adel", 32'(out_adel), 32'd0);
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (prev_pend && !redirect && !cpu_rst) begin
      chk("hold_req", 32'(inst_req), 32'd1);
      chk("hold_addr", inst_addr, prev_addr);
    end
    prev_pend = inst_req && !inst_addr_ok;
    prev_addr = inst_addr;
  end

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  occ;
  } vec_t;

  function automatic vec_t mk(logic rdy, logic req, logic [31:0] addr, logic valid,
                              logic [31:0] pc, logic [2:0] occ);
    vec_t v;
    v.rdy = rdy; v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.occ = occ;
    return v;
  endfunction

  task automatic step();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  initial begin
    vec_t tbl[14];
    int p0;
    tbl[0]  = mk(1, 1, B + 32'h00, 0, 32'h0,      3'd0);
    tbl[1]  = mk(1, 1, B + 32'h04, 0, 32'h0,      3'd1);
    tbl[2]  = mk(1, 1, B + 32'h08, 1, B + 32'h00, 3'd2);
    tbl[3]  = mk(1, 1, B + 32'h0C, 1, B + 32'h04, 3'd2);
    tbl[4]  = mk(1, 1, B + 32'h10, 1, B + 32'h08, 3'd2);
    tbl[5]  = mk(1, 1, B + 32'h14, 1, B + 32'h0C, 3'd2);
    tbl[6]  = mk(0, 1, B + 32'h18, 1, B + 32'h10, 3'd2);
    tbl[7]  = mk(0, 1, B + 32'h1C, 1, B + 32'h10, 3'd3);
    tbl[8]  = mk(0, 0, B + 32'h20, 1, B + 32'h10, 3'd4);
    tbl[9]  = mk(0, 0, B + 32'h20, 1, B + 32'h10, 3'd4);
    tbl[10] = mk(1, 0, B + 32'h20, 1, B + 32'h10, 3'd4);
    tbl[11] = mk(0, 1, B + 32'h20, 1, B + 32'h14, 3'd3);
    tbl[12] = mk(0, 0, B + 32'h24, 1, B + 32'h14, 3'd4);
    tbl[13] = mk(0, 0, B + 32'h24, 1, B + 32'h14, 3'd4);

    // Reset state.
    step();
    @(negedge cpu_clk_50M);
    chk("rst_req",   32'(inst_req),  32'd0);
    chk("rst_addr",  inst_addr,      B);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc",    out_pc,         32'd0);
    chk("rst_inst",  out_inst,       32'd0);
    chk("rst_adel",  32'(out_adel),  32'd0);
    chk("rst_occ",   32'(occupancy), 32'd0);
    step();
    mon_en = 1'b1;
    exp_pc = B;

    // Zero-wait stream, then fill to DEPTH with out_ready low and release one pop.
    for (int i = 0; i < 14; i++) begin
      step();
      cpu_rst   = 1'b0;
      out_ready = tbl[i].rdy;
      @(negedge cpu_clk_50M);
      chk($sformatf("v%0d_req", i),   32'(inst_req),  32'(tbl[i].req));
      chk($sformatf("v%0d_addr", i),  inst_addr,      tbl[i].addr);
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].valid));
      chk($sformatf("v%0d_occ", i),   32'(occupancy), 32'(tbl[i].occ));
      if (tbl[i].valid) begin
        chk($sformatf("v%0d_pc", i),   out_pc,   tbl[i].pc);
        chk($sformatf("v%0d_inst", i), out_inst, mem(tbl[i].pc));
      end
    end

    // Latency 3 with random address stalls.
    step();
    out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_1000; exp_pc = 32'h0000_1000;
    bus_mode = 1; bus_k = 3;
    step();
    redirect = 1'b0; out_ready = 1'b1;
    p0 = pops;
    repeat (60) step();
    @(negedge cpu_clk_50M);
    chk("rand_progress", 32'((pops - p0) >= 8), 32'd1);

    // Drain, then put exactly two requests in flight and redirect.
    step();
    bus_mode = 2; budget = 0;
    repeat (12) step();
    @(negedge cpu_clk_50M);
    chk("drain_occ", 32'(occupancy), 32'd0);
    step();
    bus_k = 5; budget = 2;
    step();
    step();
    @(negedge cpu_clk_50M);
    chk("two_inflight_occ", 32'(occupancy), 32'd2);
    step();
    redirect = 1'b1; redirect_pc = 32'h8000_1000; exp_pc = 32'h8000_1000; bus_mode = 0;
    step();
    redirect = 1'b0;
    @(negedge cpu_clk_50M);
    chk("redir_valid", 32'(out_valid), 32'd0);
    chk("redir_req",   32'(inst_req),  32'd1);
    chk("redir_addr",  inst_addr,      32'h8000_1000);
    p0 = pops;
    repeat (30) step();
    @(negedge cpu_clk_50M);
    chk("redir_progress", 32'(pops > p0), 32'd1);

    // Misaligned redirect: single ADEL entry, fetch halted.
    step();
    mon_en = 1'b0; out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h8000_1002;
    step();
    redirect = 1'b0;
    @(negedge cpu_clk_50M);
    chk("adel_req0",   32'(inst_req),  32'd0);
    chk("adel_valid0", 32'(out_valid), 32'd0);
    step();
    @(negedge cpu_clk_50M);
    chk("adel_valid", 32'(out_valid), 32'd1);
    chk("adel_flag",  32'(out_adel),  32'd1);
    chk("adel_inst",  out_inst,       32'd0);
    chk("adel_pc",    out_pc,         32'h8000_1002);
    chk("adel_occ",   32'(occupancy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge cpu_clk_50M);
      chk($sformatf("halt%0d_occ", i), 32'(occupancy), 32'd1);
      chk($sformatf("halt%0d_req", i), 32'(inst_req),  32'd0);
    end
    step();
    redirect = 1'b1; redirect_pc = 32'h8000_2000; exp_pc = 32'h8000_2000; mon_en = 1'b1;
    step();
    redirect = 1'b0; out_ready = 1'b1;
    @(negedge cpu_clk_50M);
    chk("resume_valid", 32'(out_valid), 32'd0);
    chk("resume_req",   32'(inst_req),  32'd1);
    chk("resume_addr",  inst_addr,      32'h8000_2000);
    p0 = pops;
    repeat (20) step();
    @(negedge cpu_clk_50M);
    chk("resume_progress", 32'(pops > p0), 32'd1);

    // Reset mid-burst.
    step();
    cpu_rst = 1'b1; mon_en = 1'b0; bus_k = 1;
    @(negedge cpu_clk_50M);
    chk("mrst_req_in_rst", 32'(inst_req), 32'd0);
    step();
    cpu_rst = 1'b0;
    @(negedge cpu_clk_50M);
    chk("mrst_req",   32'(inst_req),  32'd1);
    chk("mrst_addr",  inst_addr,      B);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_pc",    out_pc,         32'd0);
    chk("mrst_inst",  out_inst,       32'd0);
    chk("mrst_adel",  32'(out_adel),  32'd0);
    chk("mrst_occ",   32'(occupancy), 32'd0);
    mon_en = 1'b1; exp_pc = B;
    p0 = pops;
    repeat (12) step();
    @(negedge cpu_clk_50M);
    chk("mrst_progress", 32'((pops - p0) >= 8), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
